// File: rtl/requant_ctrl.sv
// Row sequencer for a fixed-latency requantizer: bias fetch, credit-limited issue, output skid FIFO.
// Optional stall counter enabled with `define REQUANT_CTRL_PERF_EN.
module requant_ctrl #(
    parameter int unsigned LANES      = 16,
    parameter int unsigned ACC_BITS   = 32,
    parameter int unsigned OUT_BITS   = 8,
    parameter int unsigned PIPE_LAT   = 3,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BIAS_AW    = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         start_i,
    input  logic [15:0]                  cfg_rows_i,
    input  logic [BIAS_AW-1:0]           cfg_bias_addr_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         bias_rd_en_o,
    output logic [BIAS_AW-1:0]           bias_addr_o,
    input  logic [LANES*32-1:0]          bias_rdata_i,
    input  logic                         acc_valid_i,
    output logic                         acc_ready_o,
    input  logic [LANES*ACC_BITS-1:0]    acc_data_i,
    output logic                         rq_en_o,
    output logic [LANES*ACC_BITS-1:0]    rq_in_acc_o,
    output logic [LANES*32-1:0]          rq_bias_o,
    input  logic                         rq_out_valid_i,
    input  logic [LANES*OUT_BITS-1:0]    rq_out_q_i,
    output logic                         wb_valid_o,
    input  logic                         wb_ready_i,
    output logic [LANES*OUT_BITS-1:0]    wb_data_o,
    output logic                         wb_last_o,
    output logic [31:0]                  perf_stall_cycles_o
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IflW = $clog2(PIPE_LAT + 1);
    localparam int unsigned OccW = CntW + IflW;
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned RowW = LANES * OUT_BITS;

    typedef enum logic [2:0] {StIdle, StBiasRd, StBiasWait, StRun, StDrain} state_e;

    state_e              state_q, state_d;
    logic [15:0]         rows_q, rows_d;
    logic [BIAS_AW-1:0]  addr_q, addr_d;
    logic [LANES*32-1:0] bias_q, bias_d;
    logic [15:0]         issued_q, issued_d;
    logic [15:0]         pop_idx_q, pop_idx_d;
    logic [IflW-1:0]     inflight_q, inflight_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [RowW-1:0]     mem_q [FIFO_DEPTH];

    logic live, run, idle_start, has_free, acc_ready, rq_en, push, pop, fifo_valid, drained;
    logic [OccW-1:0] occ;

    assign live       = !reset_i;
    assign run        = (state_q == StRun);
    assign idle_start = (state_q == StIdle) && start_i;
    // Credits come from registered counts only; a pop frees a slot one cycle later.
    assign occ        = OccW'(count_q) + OccW'(inflight_q);
    assign has_free   = occ < OccW'(FIFO_DEPTH);
    assign acc_ready  = run && (issued_q < rows_q) && has_free;
    assign rq_en      = acc_valid_i && acc_ready;
    assign push       = rq_out_valid_i && (inflight_q != '0);
    assign fifo_valid = (count_q != '0);
    assign pop        = fifo_valid && wb_ready_i;
    assign drained    = (inflight_q == '0) && (count_q == '0);

    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        addr_d    = addr_q;
        bias_d    = bias_q;
        issued_d  = issued_q;
        pop_idx_d = pop_idx_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    rows_d    = cfg_rows_i;
                    addr_d    = cfg_bias_addr_i;
                    issued_d  = '0;
                    pop_idx_d = '0;
                    state_d   = StBiasRd;
                end
            end
            StBiasRd:   state_d = StBiasWait;
            StBiasWait: begin
                bias_d  = bias_rdata_i;
                state_d = (rows_q == '0) ? StDrain : StRun;
            end
            StRun:   if (issued_q == rows_q) state_d = StDrain;
            StDrain: if (drained) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (rq_en) issued_d = issued_q + 16'd1;
        if (pop) pop_idx_d = pop_idx_q + 16'd1;
    end

    always_comb begin
        inflight_d = inflight_q + IflW'(rq_en) - IflW'(push);
        count_d    = count_q + CntW'(push) - CntW'(pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        if (pop) rd_ptr_d = (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            rows_q     <= '0;
            addr_q     <= '0;
            bias_q     <= '0;
            issued_q   <= '0;
            pop_idx_q  <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            addr_q     <= addr_d;
            bias_q     <= bias_d;
            issued_q   <= issued_d;
            pop_idx_q  <= pop_idx_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= rq_out_q_i;
    end

    // Outputs are forced low for the whole time reset is high, including its first cycle.
    assign busy_o       = live && (state_q != StIdle);
    assign done_o       = live && (state_q == StDrain) && drained;
    assign bias_rd_en_o = live && (state_q == StBiasRd);
    assign bias_addr_o  = bias_rd_en_o ? addr_q : '0;
    assign acc_ready_o  = live && acc_ready;
    assign rq_en_o      = live && rq_en;
    assign rq_in_acc_o  = live ? acc_data_i : '0;
    assign rq_bias_o    = live ? bias_q : '0;
    assign wb_valid_o   = live && fifo_valid;
    assign wb_data_o    = wb_valid_o ? mem_q[rd_ptr_q] : '0;
    assign wb_last_o    = wb_valid_o && (pop_idx_q == rows_q - 16'd1);

`ifdef REQUANT_CTRL_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (idle_start) begin
            stall_d = '0;
        end else if (run && acc_valid_i && !acc_ready && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) stall_q <= '0;
        else         stall_q <= stall_d;
    end

    assign perf_stall_cycles_o = live ? stall_q : '0;
`else
    logic unused_idle_start;
    assign unused_idle_start   = idle_start;
    assign perf_stall_cycles_o = '0;
`endif

endmodule
